vram_write_arbiter: RTL and testbench
=====================================

VRAM_WRITE_ARBITER -- requirements
Module: vram_write_arbiter

Interface
REQ-001 Parameter: ADDR_WIDTH, default 13, byte-address width of the video RAM (depth 2^ADDR_WIDTH bytes).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 cpu_req  in  1  CPU word-store request.
REQ-005 cpu_ready  out  1  store accepted on a rising edge where cpu_req && cpu_ready.
REQ-006 cpu_addr  in  32  byte address of the word; bits [1:0] ignored.
REQ-007 cpu_wdata  in  32  store data, little-endian; lane i = bits [8i+7:8i].
REQ-008 cpu_be  in  4  lane enables, bit i enables lane i.
REQ-009 clr_start  in  1  start a full-RAM fill.
REQ-010 clr_byte  in  8  fill value, sampled with clr_start.
REQ-011 clr_busy  out  1  fill in progress.
REQ-012 clr_done  out  1  one-cycle pulse after the final fill byte.
REQ-013 err_range  out  1  sticky flag: out-of-range store accepted.
REQ-014 wea  out  1  RAM write enable, registered.
REQ-015 addra  out  32  RAM byte address, registered.
REQ-016 dina  out  8  RAM write byte, registered.

Function
REQ-017 States: IDLE, CPU_WR; the fill engine (clr_busy, 2^ADDR_WIDTH-position counter, latched fill byte, last_cpu flag) runs alongside.
REQ-018 cpu_ready = (state==IDLE) && !(clr_busy && last_cpu); combinational.
REQ-019 Accept edge: latch word address cpu_addr[31:2], cpu_wdata and lane mask = cpu_be; set last_cpu=1; wea=0 on that edge.
REQ-020 Accept with cpu_be==0, or cpu_addr[31:ADDR_WIDTH]!=0: no RAM write, state stays IDLE; the out-of-range case sets err_range=1.
REQ-021 Otherwise state goes to CPU_WR; each following edge emits the lowest set lane i (wea=1, addra={cpu_addr[31:2],i[1:0]}, dina=lane i) and clears it.
REQ-022 Disabled lanes consume no cycles; k enabled lanes give wea high on exactly k consecutive edges after the accept edge.
REQ-023 State returns to IDLE on the edge that emits the last enabled lane; cpu_ready can rise in the following cycle.
REQ-024 clr_start while clr_busy==0: clr_busy<=1, counter<=0, fill byte<=clr_byte.
REQ-025 clr_start while clr_busy==1 (including the final-byte edge): ignored.
REQ-026 In IDLE, on an edge with no accept and clr_busy==1: emit wea=1, addra=counter (zero-extended), dina=fill byte; counter increments; last_cpu<=0.
REQ-027 Fill emitting address 2^ADDR_WIDTH-1: clr_busy<=0 on that edge; clr_done=1 for exactly the next cycle.
REQ-028 Arbitration: a CPU word completes atomically; after each CPU word, at most one fill byte is issued before the next CPU accept. A fill never blocks the CPU for more than one cycle, and the CPU never starves a fill.
REQ-029 clr_start on the same edge as a CPU accept: both take effect.
REQ-030 wea=0 on every edge that emits no byte; addra/dina hold their last values.
REQ-031 Only one write per cycle; RAM-side writes occur in the order emitted.

Reset
REQ-032 On rst: state=IDLE, wea=0, addra=0, dina=0, clr_busy=0, clr_done=0, err_range=0, last_cpu=0, counter=0, lane mask=0.
REQ-033 Reset mid-word discards the remaining lanes; reset mid-fill aborts it with no clr_done pulse.

Verification
REQ-034 Store addr=0x104, data=0xAABBCCDD, be=0xF -> edges E1..E4: (0x104,DD),(0x105,CC),(0x106,BB),(0x107,AA); cpu_ready=1 in the cycle after E4.
REQ-035 Store addr=0x20, be=0b1010, data=0x11223344 -> exactly 2 writes: (0x21,0x33),(0x23,0x11); wea low otherwise.
REQ-036 Store addr=0x2000 (ADDR_WIDTH=13), be=0xF -> no wea; err_range=1 and stays 1 until rst.
REQ-037 clr_start with clr_byte=0x20, no CPU traffic -> 8192 consecutive writes addresses 0..0x1FFF of 0x20; clr_done pulses once; clr_busy falls on the last write edge.
REQ-038 Fill running plus continuous cpu_req with be=0xF -> pattern of 4 CPU bytes, then 1 fill byte, repeating; cpu_ready low in each fill-slot cycle.
REQ-039 Assert rst at fill counter 100 with a CPU word half-emitted -> all outputs at reset values immediately; no clr_done; next clr_start restarts from address 0.

Source files
------------

// File: rtl/vram_write_arbiter.sv
// Byte-wide write port arbiter for the video RAM: splits CPU word stores into
// per-lane byte writes and interleaves a background full-RAM fill engine.
module vram_write_arbiter #(
    parameter int ADDR_WIDTH = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    output logic        cpu_ready,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_be,
    input  logic        clr_start,
    input  logic [7:0]  clr_byte,
    output logic        clr_busy,
    output logic        clr_done,
    output logic        err_range,
    output logic        wea,
    output logic [31:0] addra,
    output logic [7:0]  dina
);

    typedef enum logic {
        IDLE,
        CPU_WR
    } state_t;

    state_t                state;
    logic [29:0]           word_addr;
    logic [31:0]           word_data;
    logic [3:0]            lane_mask;
    logic                  last_cpu;
    logic [ADDR_WIDTH-1:0] fill_count;
    logic [7:0]            fill_byte;

    logic                  accept;
    logic                  addr_in_range;
    logic [1:0]            lane_sel;
    logic [3:0]            lane_mask_next;

    // The fill gets exactly one slot after each CPU word, so the CPU is held
    // off only while a fill is pending and the previous winner was the CPU.
    assign cpu_ready     = (state == IDLE) && !(clr_busy && last_cpu);
    assign accept        = cpu_req && cpu_ready;
    assign addr_in_range = (cpu_addr >> ADDR_WIDTH) == 32'd0;

    always_comb begin
        lane_sel = 2'd0;
        if (lane_mask[0])
            lane_sel = 2'd0;
        else if (lane_mask[1])
            lane_sel = 2'd1;
        else if (lane_mask[2])
            lane_sel = 2'd2;
        else if (lane_mask[3])
            lane_sel = 2'd3;
        lane_mask_next = lane_mask & (lane_mask - 4'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            word_addr  <= '0;
            word_data  <= '0;
            lane_mask  <= '0;
            last_cpu   <= 1'b0;
            fill_count <= '0;
            fill_byte  <= '0;
            clr_busy   <= 1'b0;
            clr_done   <= 1'b0;
            err_range  <= 1'b0;
            wea        <= 1'b0;
            addra      <= '0;
            dina       <= '0;
        end else begin
            wea      <= 1'b0;
            clr_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        word_addr <= cpu_addr[31:2];
                        word_data <= cpu_wdata;
                        lane_mask <= cpu_be;
                        last_cpu  <= 1'b1;
                        if (!addr_in_range)
                            err_range <= 1'b1;
                        else if (cpu_be != 4'd0)
                            state <= CPU_WR;
                    end else if (clr_busy) begin
                        wea        <= 1'b1;
                        addra      <= 32'(fill_count);
                        dina       <= fill_byte;
                        fill_count <= fill_count + ADDR_WIDTH'(1);
                        last_cpu   <= 1'b0;
                        if (&fill_count) begin
                            clr_busy <= 1'b0;
                            clr_done <= 1'b1;
                        end
                    end
                end
                CPU_WR: begin
                    wea       <= 1'b1;
                    addra     <= {word_addr, lane_sel};
                    dina      <= word_data[{lane_sel, 3'b000} +: 8];
                    lane_mask <= lane_mask_next;
                    if (lane_mask_next == 4'd0)
                        state <= IDLE;
                end
            endcase

            // A new fill may only be launched while none is running.
            if (clr_start && !clr_busy) begin
                clr_busy   <= 1'b1;
                fill_count <= '0;
                fill_byte  <= clr_byte;
            end
        end
    end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Bench for vram_write_arbiter: directed store table, fill/arbitration
// sequences and randomized traffic against a queue-based reference model.
module tb_vram_write_arbiter;

    localparam int ADDR_WIDTH = 13;
    localparam int DEPTH      = 1 << ADDR_WIDTH;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_ready;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_be;
    logic        clr_start;
    logic [7:0]  clr_byte;
    logic        clr_busy;
    logic        clr_done;
    logic        err_range;
    logic        wea;
    logic [31:0] addra;
    logic [7:0]  dina;

    vram_write_arbiter #(.ADDR_WIDTH(ADDR_WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_ready (cpu_ready),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_be    (cpu_be),
        .clr_start (clr_start),
        .clr_byte  (clr_byte),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .err_range (err_range),
        .wea       (wea),
        .addra     (addra),
        .dina      (dina)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: pending CPU bytes as a queue plus a fill cursor.
    typedef struct packed {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t         m_q[$];
    bit          m_fill, m_owed, m_done, m_err, m_wea;
    int          m_pos;
    logic [7:0]  m_val;
    logic [31:0] m_addra;
    logic [7:0]  m_dina;

    typedef struct packed {
        logic [31:0]      addr;
        logic [31:0]      data;
        logic [3:0]       be;
        logic [2:0]       n;
        logic [3:0][31:0] wa;
        logic [3:0][7:0]  wd;
        logic             err;
    } store_vec_t;

    store_vec_t vecs [8];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_fill  = 0;
        m_owed  = 0;
        m_done  = 0;
        m_err   = 0;
        m_wea   = 0;
        m_pos   = 0;
        m_val   = 8'h00;
        m_addra = 32'h0;
        m_dina  = 8'h00;
    endtask

    // Advance the model and the DUT by one clock edge, then compare.
    task automatic apply_stimulus();
        bit  ready, acc, fill_was;
        wr_t w;
        ready = (m_q.size() == 0) && !(m_fill && m_owed);
        check_output("cpu_ready", {31'd0, cpu_ready}, {31'd0, ready});
        acc      = cpu_req && ready;
        fill_was = m_fill;
        m_wea    = 0;
        m_done   = 0;
        if (m_q.size() > 0) begin
            w       = m_q.pop_front();
            m_wea   = 1;
            m_addra = w.a;
            m_dina  = w.d;
        end else if (!acc && m_fill) begin
            m_wea   = 1;
            m_addra = 32'(m_pos);
            m_dina  = m_val;
            m_pos++;
            m_owed  = 0;
            if (m_pos == DEPTH) begin
                m_fill = 0;
                m_done = 1;
            end
        end
        if (acc) begin
            m_owed = 1;
            if (cpu_addr >= 32'(DEPTH))
                m_err = 1;
            else
                for (int i = 0; i < 4; i++)
                    if (cpu_be[i])
                        m_q.push_back('{a: (cpu_addr & ~32'h3) + 32'(i), d: 8'(cpu_wdata >> (8 * i))});
        end
        if (clr_start && !fill_was) begin
            m_fill = 1;
            m_pos  = 0;
            m_val  = clr_byte;
        end
        @(posedge clk);
        #1;
        clr_start = 1'b0;
        check_output("wea", {31'd0, wea}, {31'd0, m_wea});
        check_output("addra", addra, m_addra);
        check_output("dina", {24'd0, dina}, {24'd0, m_dina});
        check_output("clr_busy", {31'd0, clr_busy}, {31'd0, m_fill});
        check_output("clr_done", {31'd0, clr_done}, {31'd0, m_done});
        check_output("err_range", {31'd0, err_range}, {31'd0, m_err});
    endtask

    task automatic check_reset_values(input string tag);
        check_output($sformatf("%s_wea", tag), {31'd0, wea}, 32'd0);
        check_output($sformatf("%s_addra", tag), addra, 32'd0);
        check_output($sformatf("%s_dina", tag), {24'd0, dina}, 32'd0);
        check_output($sformatf("%s_busy", tag), {31'd0, clr_busy}, 32'd0);
        check_output($sformatf("%s_done", tag), {31'd0, clr_done}, 32'd0);
        check_output($sformatf("%s_err", tag), {31'd0, err_range}, 32'd0);
        check_output($sformatf("%s_ready", tag), {31'd0, cpu_ready}, 32'd1);
    endtask

    // Pulse reset between clock edges so its effect is purely asynchronous.
    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1 check_reset_values(tag);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic run_store(input store_vec_t v, input string tag);
        bit          accepted;
        int          cnt;
        logic [31:0] ga [4];
        logic [7:0]  gd [4];
        int          gt [4];
        accepted  = 0;
        cnt       = 0;
        cpu_req   = 1'b1;
        cpu_addr  = v.addr;
        cpu_wdata = v.data;
        cpu_be    = v.be;
        for (int t = 0; t < 20 && !accepted; t++) begin
            accepted = cpu_ready;
            apply_stimulus();
        end
        cpu_req = 1'b0;
        check_output($sformatf("%s_accept", tag), {31'd0, accepted}, 32'd1);
        for (int t = 0; t < 6; t++) begin
            apply_stimulus();
            if (wea) begin
                if (cnt < 4) begin
                    ga[cnt] = addra;
                    gd[cnt] = dina;
                    gt[cnt] = t;
                end
                cnt++;
            end
        end
        check_output($sformatf("%s_count", tag), cnt, 32'(v.n));
        for (int i = 0; i < int'(v.n) && i < cnt && i < 4; i++) begin
            check_output($sformatf("%s_addr%0d", tag, i), ga[i], v.wa[i]);
            check_output($sformatf("%s_data%0d", tag, i), {24'd0, gd[i]}, {24'd0, v.wd[i]});
            check_output($sformatf("%s_edge%0d", tag, i), gt[i], i);
        end
        check_output($sformatf("%s_err", tag), {31'd0, err_range}, {31'd0, v.err});
        check_output($sformatf("%s_ready_after", tag), {31'd0, cpu_ready}, 32'd1);
    endtask

    initial begin
        int  fill_seen, run_len, acc_n, writes, done_cnt;
        bit  stop, late_poked;

        vecs[0] = '{addr: 32'h104, data: 32'hAABBCCDD, be: 4'hF, n: 3'd4,
                    wa: {32'h107, 32'h106, 32'h105, 32'h104}, wd: {8'hAA, 8'hBB, 8'hCC, 8'hDD}, err: 1'b0};
        vecs[1] = '{addr: 32'h20, data: 32'h11223344, be: 4'b1010, n: 3'd2,
                    wa: {32'h0, 32'h0, 32'h23, 32'h21}, wd: {8'h00, 8'h00, 8'h11, 8'h33}, err: 1'b0};
        vecs[2] = '{addr: 32'h1FFF, data: 32'h55667788, be: 4'b1000, n: 3'd1,
                    wa: {32'h0, 32'h0, 32'h0, 32'h1FFF}, wd: {8'h00, 8'h00, 8'h00, 8'h55}, err: 1'b0};
        vecs[3] = '{addr: 32'h40, data: 32'hDEADBEEF, be: 4'b0000, n: 3'd0,
                    wa: {4{32'h0}}, wd: {4{8'h00}}, err: 1'b0};
        vecs[4] = '{addr: 32'h1237, data: 32'hCAFEF00D, be: 4'b0101, n: 3'd2,
                    wa: {32'h0, 32'h0, 32'h1236, 32'h1234}, wd: {8'h00, 8'h00, 8'hFE, 8'h0D}, err: 1'b0};
        vecs[5] = '{addr: 32'h2000, data: 32'h12345678, be: 4'hF, n: 3'd0,
                    wa: {4{32'h0}}, wd: {4{8'h00}}, err: 1'b1};
        vecs[6] = '{addr: 32'h8, data: 32'h01020304, be: 4'b0010, n: 3'd1,
                    wa: {32'h0, 32'h0, 32'h0, 32'h9}, wd: {8'h00, 8'h00, 8'h00, 8'h03}, err: 1'b1};
        vecs[7] = '{addr: 32'hFFFFFFFC, data: 32'h0BADF00D, be: 4'b0001, n: 3'd0,
                    wa: {4{32'h0}}, wd: {4{8'h00}}, err: 1'b1};

        rst       = 1'b1;
        cpu_req   = 1'b0;
        cpu_addr  = 32'h0;
        cpu_wdata = 32'h0;
        cpu_be    = 4'h0;
        clr_start = 1'b0;
        clr_byte  = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;
        repeat (2) apply_stimulus();

        for (int v = 0; v < 8; v++)
            run_store(vecs[v], $sformatf("store%0d", v));
        async_reset("reset_after_table");

        // Fill launched on the same edge as a CPU accept, CPU kept saturated.
        clr_byte  = 8'h5A;
        clr_start = 1'b1;
        cpu_req   = 1'b1;
        cpu_be    = 4'hF;
        cpu_wdata = 32'h11223344;
        cpu_addr  = 32'h1000;
        fill_seen = 0;
        run_len   = 0;
        acc_n     = 0;
        stop      = 0;
        for (int t = 0; t < 1000 && !stop; t++) begin
            if (cpu_ready)
                acc_n++;
            apply_stimulus();
            cpu_addr = 32'h1000 + 32'(4 * (acc_n % 256));
            if (wea) begin
                if (dina == 8'h5A) begin
                    if (fill_seen > 0)
                        check_output("arb_cpu_run", run_len, 32'd4);
                    fill_seen++;
                    run_len = 0;
                end else begin
                    run_len++;
                end
            end
            if (fill_seen == 100 && run_len == 2)
                stop = 1;
        end
        check_output("arb_fill_count", fill_seen, 32'd100);
        check_output("arb_half_word", run_len, 32'd2);

        async_reset("reset_mid_fill");
        cpu_req = 1'b0;
        for (int t = 0; t < 5; t++) begin
            apply_stimulus();
            check_output("abort_no_done", {31'd0, clr_done}, 32'd0);
        end
        clr_byte  = 8'h77;
        clr_start = 1'b1;
        apply_stimulus();
        check_output("restart_busy", {31'd0, clr_busy}, 32'd1);
        apply_stimulus();
        check_output("restart_wea", {31'd0, wea}, 32'd1);
        check_output("restart_addr0", addra, 32'd0);
        check_output("restart_data", {24'd0, dina}, 32'h77);
        apply_stimulus();
        check_output("restart_addr1", addra, 32'd1);
        async_reset("reset_before_fill");

        // Full uninterrupted fill, with ignored restart attempts mid-way and on the last byte.
        clr_byte   = 8'h20;
        clr_start  = 1'b1;
        apply_stimulus();
        writes     = 0;
        done_cnt   = 0;
        late_poked = 0;
        for (int t = 0; t < DEPTH + 8; t++) begin
            if (t == 4000) begin
                clr_start = 1'b1;
                clr_byte  = 8'hEE;
            end
            if (writes == DEPTH - 1 && !late_poked) begin
                clr_start  = 1'b1;
                clr_byte   = 8'hEE;
                late_poked = 1;
            end
            apply_stimulus();
            if (clr_done)
                done_cnt++;
            if (wea) begin
                check_output("fill_addr", addra, writes);
                check_output("fill_data", {24'd0, dina}, 32'h20);
                if (addra == 32'(DEPTH - 1))
                    check_output("fill_busy_last", {31'd0, clr_busy}, 32'd0);
                writes++;
            end
        end
        check_output("fill_writes", writes, DEPTH);
        check_output("fill_done_pulses", done_cnt, 32'd1);
        check_output("fill_busy_end", {31'd0, clr_busy}, 32'd0);

        async_reset("reset_before_random");
        for (int t = 0; t < 4000; t++) begin
            cpu_req   = ($urandom_range(0, 2) != 0);
            cpu_addr  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1));
            cpu_wdata = $urandom;
            cpu_be    = 4'($urandom);
            clr_start = ($urandom_range(0, 60) == 0);
            clr_byte  = 8'($urandom);
            if ($urandom_range(0, 700) == 0)
                async_reset("reset_random");
            apply_stimulus();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
